// File: rtl/arc4_pkg.sv
// Shared constants, state encoding and helpers for the ARC4 datapath stages.
package arc4_pkg;

    localparam int ARC4_AW = 8;
    localparam int ARC4_DW = 8;

    typedef enum logic [3:0] {
        IDLE,
        LEN0,
        LEN1,
        RDI,
        RDJ,
        WRI,
        WRJ,
        RDP,
        WRP
    } prga_state_t;

    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= PRINT_LO) && (b <= PRINT_HI);
    endfunction

endpackage

// File: rtl/arc4_prga.sv
// ARC4 keystream stage: decrypts length-prefixed CT memory into PT memory using S.
// Optional build macro ARC4_PRGA_ASCII_CHECK_EN aborts on the first non-printable byte.
module arc4_prga
    import arc4_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic               rdy,
    output logic [ARC4_AW-1:0] s_addr,
    input  logic [ARC4_DW-1:0] s_rddata,
    output logic [ARC4_DW-1:0] s_wrdata,
    output logic               s_wren,
    output logic [ARC4_AW-1:0] ct_addr,
    input  logic [ARC4_DW-1:0] ct_rddata,
    output logic [ARC4_AW-1:0] pt_addr,
    output logic [ARC4_DW-1:0] pt_wrdata,
    output logic               pt_wren,
    output logic               pt_ok
);

    prga_state_t        state_q, state_d;
    logic [ARC4_DW-1:0] i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
    // k and L carry a ninth bit so L=255 ends cleanly without k wrapping.
    logic [8:0]         k_q, k_d, len_q, len_d;
    logic [ARC4_DW-1:0] pt_byte;
    logic               last_byte;

    assign pt_byte = s_rddata ^ ct_rddata;

`ifdef ARC4_PRGA_ASCII_CHECK_EN
    logic ok_q, ok_d;

    assign last_byte = (k_q == len_q) || !is_printable(pt_byte);
    assign pt_ok     = ok_q;

    always_comb begin
        ok_d = ok_q;
        if (state_q == IDLE && en) begin
            ok_d = 1'b1;
        end else if (state_q == WRP && !is_printable(pt_byte)) begin
            ok_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ok_q <= 1'b1;
        end else begin
            ok_q <= ok_d;
        end
    end
`else
    assign last_byte = (k_q == len_q);
    assign pt_ok     = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            k_q     <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            k_q     <= k_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        si_d      = si_q;
        sj_d      = sj_q;
        k_d       = k_q;
        len_d     = len_q;
        rdy       = 1'b0;
        s_addr    = '0;
        s_wrdata  = '0;
        s_wren    = 1'b0;
        ct_addr   = '0;
        pt_addr   = '0;
        pt_wrdata = '0;
        pt_wren   = 1'b0;

        case (state_q)
            IDLE: begin
                rdy = 1'b1;
                if (en) begin
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    state_d = LEN0;
                end
            end
            LEN0: begin
                ct_addr = '0;
                state_d = LEN1;
            end
            LEN1: begin
                len_d     = {1'b0, ct_rddata};
                pt_addr   = '0;
                pt_wrdata = ct_rddata;
                pt_wren   = 1'b1;
                if (ct_rddata == '0) begin
                    state_d = IDLE;
                end else begin
                    i_d     = 8'd1;
                    k_d     = 9'd1;
                    state_d = RDI;
                end
            end
            RDI: begin
                s_addr  = i_q;
                state_d = RDJ;
            end
            // s[i] arrives here; j advances and s[j] is requested in the same cycle.
            RDJ: begin
                si_d    = s_rddata;
                j_d     = j_q + s_rddata;
                s_addr  = j_q + s_rddata;
                state_d = WRI;
            end
            WRI: begin
                sj_d     = s_rddata;
                s_addr   = i_q;
                s_wrdata = s_rddata;
                s_wren   = 1'b1;
                state_d  = WRJ;
            end
            WRJ: begin
                s_addr   = j_q;
                s_wrdata = si_q;
                s_wren   = 1'b1;
                state_d  = RDP;
            end
            RDP: begin
                s_addr  = si_q + sj_q;
                ct_addr = k_q[7:0];
                state_d = WRP;
            end
            WRP: begin
                pt_addr   = k_q[7:0];
                pt_wrdata = pt_byte;
                pt_wren   = 1'b1;
                if (last_byte) begin
                    state_d = IDLE;
                end else begin
                    k_d     = k_q + 9'd1;
                    i_d     = i_q + 8'd1;
                    state_d = RDI;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_arc4_prga.sv
// Directed bench for arc4_prga with behavioural S/CT/PT memories and a software ARC4 model.
module tb_arc4_prga;
    import arc4_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       rdy;
    logic [7:0] s_addr, s_rddata, s_wrdata, ct_addr, ct_rddata, pt_addr, pt_wrdata;
    logic       s_wren, pt_wren, pt_ok;

    int checks = 0;
    int errors = 0;

    arc4_prga dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .rdy       (rdy),
        .s_addr    (s_addr),
        .s_rddata  (s_rddata),
        .s_wrdata  (s_wrdata),
        .s_wren    (s_wren),
        .ct_addr   (ct_addr),
        .ct_rddata (ct_rddata),
        .pt_addr   (pt_addr),
        .pt_wrdata (pt_wrdata),
        .pt_wren   (pt_wren),
        .pt_ok     (pt_ok)
    );

    always #5 clk = ~clk;

    // Memories with 1-cycle read latency; load copies the init images in one cycle.
    logic       load = 1'b0;
    logic [7:0] s_init[256], ct_init[256], s_mem[256], ct_mem[256], pt_mem[256];
    int         s_wr_cnt = 0, pt_wr_cnt = 0;

    always @(posedge clk) begin
        if (load) begin
            for (int a = 0; a < 256; a++) begin
                s_mem[a]  <= s_init[a];
                ct_mem[a] <= ct_init[a];
                pt_mem[a] <= 8'hAA;
            end
        end else begin
            if (s_wren) begin
                s_mem[s_addr] <= s_wrdata;
                s_wr_cnt      <= s_wr_cnt + 1;
            end
            if (pt_wren) begin
                pt_mem[pt_addr] <= pt_wrdata;
                pt_wr_cnt       <= pt_wr_cnt + 1;
            end
        end
        s_rddata  <= s_mem[s_addr];
        ct_rddata <= ct_mem[ct_addr];
    end

    typedef struct {
        int          len;
        logic [39:0] ct;
        logic [39:0] pt;
        int          cyc;
    } vec_t;

    vec_t       vecs[4];
    logic [7:0] ms[256];
    logic [7:0] exp_pt[256];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_ident();
        for (int a = 0; a < 256; a++) s_init[a] = 8'(a);
    endtask

    task automatic set_ct(input int len, input logic [39:0] bytes);
        for (int a = 0; a < 256; a++) ct_init[a] = 8'h00;
        for (int b = 0; b < 5; b++) ct_init[b] = bytes[8*b +: 8];
        ct_init[0] = 8'(len);
    endtask

    task automatic load_mems();
        @(negedge clk);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Pulses en for one accepted cycle and counts negedges spent with rdy=0.
    task automatic run(input int pulse_at, output int cyc);
        int g;
        g = 0;
        @(negedge clk);
        while (!rdy && g < 100) begin
            g++;
            @(negedge clk);
        end
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        cyc = 0;
        while (!rdy && cyc < 5000) begin
            cyc++;
            en = (cyc == pulse_at);
            @(negedge clk);
        end
        en = 1'b0;
    endtask

    task automatic model_long();
        logic [7:0] key[3];
        logic [7:0] t, ks, p;
        int         i, j;
        key[0] = 8'h00;
        key[1] = 8'h00;
        key[2] = 8'h18;
        for (int a = 0; a < 256; a++) ms[a] = 8'(a);
        j = 0;
        for (int a = 0; a < 256; a++) begin
            j = (j + int'(ms[a]) + int'(key[a % 3])) % 256;
            t = ms[a];
            ms[a] = ms[j];
            ms[j] = t;
        end
        for (int a = 0; a < 256; a++) s_init[a] = ms[a];
        i = 0;
        j = 0;
        ct_init[0] = 8'd255;
        exp_pt[0]  = 8'd255;
        for (int k = 1; k < 256; k++) begin
            i = (i + 1) % 256;
            j = (j + int'(ms[i])) % 256;
            t = ms[i];
            ms[i] = ms[j];
            ms[j] = t;
            ks = ms[(int'(ms[i]) + int'(ms[j])) % 256];
            p  = 8'($urandom_range(32, 126));
            ct_init[k] = ks ^ p;
            exp_pt[k]  = p;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc, n1, n2, gap, g, sw0, pw0, diffs;

        vecs[0] = '{len: 0, ct: 40'h0000000000, pt: 40'h0000000000, cyc: 2};
        vecs[1] = '{len: 1, ct: 40'h0000004101, pt: 40'h0000004301, cyc: 8};
        vecs[2] = '{len: 2, ct: 40'h0000204102, pt: 40'h0000254302, cyc: 14};
        vecs[3] = '{len: 4, ct: 40'h604E604804, pt: 40'h6D49654A04, cyc: 26};

        // Reset values
        #3;
        chk("rst_rdy", int'(rdy), 1);
        chk("rst_pt_ok", int'(pt_ok), 1);
        chk("rst_s_wren", int'(s_wren), 0);
        chk("rst_pt_wren", int'(pt_wren), 0);
        chk("rst_addrs", int'({s_addr, ct_addr, pt_addr}), 0);
        chk("rst_wrdata", int'({s_wrdata, pt_wrdata}), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven runs on identity S; all plaintexts printable
        for (int v = 0; v < 4; v++) begin
            set_ident();
            set_ct(vecs[v].len, vecs[v].ct);
            load_mems();
            sw0 = s_wr_cnt;
            pw0 = pt_wr_cnt;
            run(0, cyc);
            chk($sformatf("v%0d_cycles", v), cyc, vecs[v].cyc);
            chk($sformatf("v%0d_pt_ok", v), int'(pt_ok), 1);
            chk($sformatf("v%0d_pt_writes", v), pt_wr_cnt - pw0, vecs[v].len + 1);
            chk($sformatf("v%0d_s_writes", v), s_wr_cnt - sw0, 2 * vecs[v].len);
            for (int k = 0; k <= vecs[v].len; k++)
                chk($sformatf("v%0d_pt%0d", v, k), int'(pt_mem[k]), int'(vecs[v].pt[8*k +: 8]));
            chk($sformatf("v%0d_pt_beyond", v), int'(pt_mem[vecs[v].len + 1]), 8'hAA);
        end

        // Identity S, ct={02,41,00}: swap result and en pulse while busy
        set_ident();
        set_ct(2, 40'h0000004102);
        load_mems();
        pw0 = pt_wr_cnt;
        run(5, cyc);
        chk("id_cycles_pulse", cyc, 14);
        chk("id_pt1", int'(pt_mem[1]), 8'h43);
        chk("id_pt2", int'(pt_mem[2]), 8'h05);
        chk("id_s2", int'(s_mem[2]), 8'h03);
        chk("id_s3", int'(s_mem[3]), 8'h02);
        diffs = 0;
        for (int a = 0; a < 256; a++)
            if (a != 2 && a != 3 && s_mem[a] != 8'(a)) diffs++;
        chk("id_s_rest", diffs, 0);
`ifdef ARC4_PRGA_ASCII_CHECK_EN
        chk("id_pt_ok", int'(pt_ok), 0);
`else
        chk("id_pt_ok", int'(pt_ok), 1);
`endif
        repeat (3) @(negedge clk);
        chk("pulse_no_restart_rdy", int'(rdy), 1);
        chk("pulse_pt_writes", pt_wr_cnt - pw0, 3);

        // Back-to-back runs with en held high
        set_ident();
        load_mems();
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        n1 = 0;
        while (!rdy && n1 < 100) begin
            n1++;
            @(negedge clk);
        end
        gap = 0;
        while (rdy && gap < 100) begin
            gap++;
            @(negedge clk);
        end
        en = 1'b0;
        n2 = 0;
        while (!rdy && n2 < 100) begin
            n2++;
            @(negedge clk);
        end
        chk("b2b_run1", n1, 14);
        chk("b2b_gap", gap, 1);
        chk("b2b_run2", n2, 14);

        // Reset while in WRI
        set_ident();
        set_ct(2, 40'h0000004102);
        load_mems();
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        g = 0;
        while (!s_wren && g < 50) begin
            g++;
            @(negedge clk);
        end
        chk("midrst_reached_wri", int'(s_wren), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_rdy", int'(rdy), 1);
        chk("midrst_s_wren", int'(s_wren), 0);
        chk("midrst_pt_wren", int'(pt_wren), 0);
        chk("midrst_pt_ok", int'(pt_ok), 1);
        @(negedge clk);
        rst_n = 1'b1;
        set_ident();
        load_mems();
        run(0, cyc);
        chk("postrst_cycles", cyc, 14);
        chk("postrst_pt1", int'(pt_mem[1]), 8'h43);
        chk("postrst_pt2", int'(pt_mem[2]), 8'h05);

        // ct={03,41,00,41}: third byte only processed without the ASCII check
        set_ident();
        set_ct(3, 40'h0041004103);
        load_mems();
        run(0, cyc);
        chk("asc_pt0", int'(pt_mem[0]), 8'h03);
        chk("asc_pt2", int'(pt_mem[2]), 8'h05);
`ifdef ARC4_PRGA_ASCII_CHECK_EN
        chk("asc_cycles", cyc, 14);
        chk("asc_pt_ok", int'(pt_ok), 0);
        chk("asc_pt3", int'(pt_mem[3]), 8'hAA);
`else
        chk("asc_cycles", cyc, 20);
        chk("asc_pt_ok", int'(pt_ok), 1);
        chk("asc_pt3", int'(pt_mem[3]), 8'h46);
`endif

        // L=255 from KSA(key 000018) with printable plaintext against the software model
        model_long();
        load_mems();
        run(0, cyc);
        chk("long_cycles", cyc, 1532);
        chk("long_pt_ok", int'(pt_ok), 1);
        for (int k = 0; k < 256; k++)
            chk($sformatf("long_pt%0d", k), int'(pt_mem[k]), int'(exp_pt[k]));
        diffs = 0;
        for (int a = 0; a < 256; a++)
            if (s_mem[a] != ms[a]) diffs++;
        chk("long_s_diffs", diffs, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
